regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RV32I core. Configurable width, depth and number of combinational read ports.
- Adds a per-register scoreboard, so decode can stall on RAW and WAW hazards against in-flight writebacks.
- Sits between decode/issue, which reads operands and reserves destinations, and writeback, which writes results and clears reservations.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers. Register 0 is hardwired to zero.
- AW, 5, address width. Must equal clog2(NREGS).
- NRP, 2, number of read ports.
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to the read ports.

Ports:
- i_clk  in  1  CPU clock.
- i_rst_n  in  1  active-low reset.
- i_rd_addr  in  NRP*AW  read addresses, flattened; port k occupies bits [k*AW +: AW].
- o_rd_data  out  NRP*XLEN  read data, port k occupies bits [k*XLEN +: XLEN].
- o_rd_busy  out  NRP  bit k = 1 when the register addressed by port k has a pending write.
- i_wr_en  in  1  writeback enable.
- i_wr_addr  in  AW  writeback destination.
- i_wr_data  in  XLEN  writeback data.
- i_rsv_en  in  1  issue requests a reservation on a destination register.
- i_rsv_addr  in  AW  register to reserve.
- o_rsv_ready  out  1  reservation is accepted this cycle.
- o_busy_vec  out  NREGS  raw scoreboard state; bit 0 is always 0.

Behaviour:
- Clock and reset (already decided): one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset clears all registers and all busy bits immediately. With i_rst_n low:
  - o_rd_data = 0 for every port.
  - o_rd_busy = 0.
  - o_busy_vec = 0.
  - o_rsv_ready = 1.
  - Reset asserted mid-operation discards all pending reservations and register contents in that same instant.
- Reads are combinational (0-cycle latency), port k:
  - Address 0: data = 0, busy = 0.
  - Else, if BYPASS = 1 and i_wr_en = 1 and i_wr_addr equals the read address: data = i_wr_data, busy = 0.
  - Else: data = stored value, busy = busy bit of that register.
  - With BYPASS = 0, the bypass row is skipped. Reads return the old value and the current busy bit until the next edge.
  - All read ports are independent. Any ports may carry the same address.
- Write, on the rising edge of i_clk:
  - If i_wr_en = 1 and i_wr_addr != 0, the register takes i_wr_data.
  - Writes to address 0 are ignored.
  - A write to a non-busy register is legal and leaves its busy bit at 0.
- Reservation:
  - o_rsv_ready = (i_rsv_addr == 0) OR NOT busy[i_rsv_addr] OR (i_wr_en AND i_wr_addr == i_rsv_addr).
  - o_rsv_ready is combinational and does not depend on i_rsv_en.
  - A reservation is accepted on a cycle with i_rsv_en = 1 and o_rsv_ready = 1.
  - An accepted reservation with address != 0 sets that register's busy bit at the edge.
  - Reserving address 0 is accepted and has no effect.
  - A request with o_rsv_ready = 0 is refused and changes nothing. Issue holds the request until ready.
- Busy bit next state, per register r != 0:
  - Set if a reservation on r is accepted.
  - Else cleared if a write to r occurs.
  - Else held.
  - When a write and a reservation hit the same r in one cycle, the data is written AND busy ends at 1: the new reservation wins over the completing write.
- Simultaneous events:
  - A write and a reservation on different registers take effect together.
  - A read of a register being reserved in the same cycle still shows the pre-edge busy value.
- Width rules:
  - Address values >= NREGS (when NREGS < 2^AW) read as 0 with busy = 0.
  - Writes and reservations to such addresses are ignored.

Test Plan:
- Reset: write x5 = 0xDEADBEEF, then pulse i_rst_n low for half a cycle, between clock edges -> read x5 returns 0 and o_busy_vec = 0 immediately, without waiting for a clock edge.
- Basic read/write with x0: write x0 = 0x1234 and x31 = 0xA5A5A5A5; set port0 = 0, port1 = 31 -> port 0 reads 0, port 1 reads 0xA5A5A5A5.
- Bypass (BYPASS = 1): x7 holds 0x11. In one cycle write x7 = 0x22 and read x7 on both ports -> both read 0x22 with busy = 0. Repeat with BYPASS = 0 -> both read 0x11 until the edge.
- Scoreboard RAW: reserve x3 -> next cycle o_rd_busy for x3 = 1. Write x3 = 0x99 -> the same-cycle read shows 0x99 with busy = 0, and the following cycle busy = 0.
- WAW stall: x4 busy. Reserve x4 with no write -> o_rsv_ready = 0 and busy stays 1. Reserve x4 in the same cycle as writeback to x4 -> ready = 1, x4 = new data, busy[4] = 1 after the edge.
- x0 reservation and multiport: reserve x0 -> ready = 1 and o_busy_vec stays 0. With NRP = 3, all ports at x9 = 0x5 -> all three ports read 0x5.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file for the RV32I core, with a per-register scoreboard.
//   Decode/issue reads its operands and reserves destination registers.
//   Writeback writes the results and clears the reservations.
//   Register 0 always reads as zero, and its busy bit is always zero.
//
// Ports
//   i_clk, i_rst_n     clock; asynchronous active-low reset
//   i_rd_addr          NRP read addresses, port k at [k*AW +: AW]
//   o_rd_data          NRP read data words, port k at [k*XLEN +: XLEN] (combinational)
//   o_rd_busy          per-port pending-write flag (combinational)
//   i_wr_en/addr/data  writeback port
//   i_rsv_en/addr      destination reservation request
//   o_rsv_ready        reservation can be accepted this cycle (independent of i_rsv_en)
//   o_busy_vec         raw scoreboard state
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NRP*AW-1:0]    i_rd_addr,
    output logic [NRP*XLEN-1:0]  o_rd_data,
    output logic [NRP-1:0]       o_rd_busy,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [XLEN-1:0]      i_wr_data,
    input  logic                 i_rsv_en,
    input  logic [AW-1:0]        i_rsv_addr,
    output logic                 o_rsv_ready,
    output logic [NREGS-1:0]     o_busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             wr_ok, rsv_acc;

    // A writable register: not x0, and inside the implemented range.
    // Addresses at or above NREGS only exist when NREGS is not a power of two.
    function automatic logic live_addr(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < 32'(NREGS));
    endfunction

    assign wr_ok = i_wr_en && live_addr(i_wr_addr);

    // A reservation is refused only on a live register that is still busy.
    // The exception is a register that writeback completes in this same cycle.
    always_comb begin
        o_rsv_ready = 1'b1;
        if (live_addr(i_rsv_addr) && busy_q[i_rsv_addr] &&
            !(i_wr_en && (i_wr_addr == i_rsv_addr)))
            o_rsv_ready = 1'b0;
    end

    assign rsv_acc = i_rsv_en && o_rsv_ready && live_addr(i_rsv_addr);

    // The reservation is applied after the write.
    // When both hit the same register, the new reservation therefore wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)   busy_d[i_wr_addr]  = 1'b0;
        if (rsv_acc) busy_d[i_rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            busy_q <= busy_d;
            if (wr_ok) regs_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_busy_vec = busy_q;

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = i_rd_addr[k*AW +: AW];

        // Storage is already cleared asynchronously, but the bypass path is not.
        // Gating on i_rst_n keeps every read at zero while reset is held.
        always_comb begin
            data = '0;
            busy = 1'b0;
            if (i_rst_n && live_addr(addr)) begin
                if (BYPASS != 0 && i_wr_en && (i_wr_addr == addr)) begin
                    data = i_wr_data;
                end else begin
                    data = regs_q[addr];
                    busy = busy_q[addr];
                end
            end
        end

        assign o_rd_data[k*XLEN +: XLEN] = data;
        assign o_rd_busy[k]              = busy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Drives two instances from one stimulus stream:
//     A: 3 read ports, bypass on, 32 registers.
//     B: 2 read ports, bypass off, 24 registers (so addresses 24..31 are out of range).
//   The driver computes the expected combinational outputs from a reference model and queues them.
//   The monitor pops and compares them on the falling edge.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  pa0 = '0, pa1 = '0, pa2 = '0;
    logic        we = 1'b0, re = 1'b0;
    logic [4:0]  wa = '0, ra = '0;
    logic [31:0] wd = '0;

    logic [14:0] rd_addr_a;
    logic [9:0]  rd_addr_b;
    logic [95:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [2:0]  rd_busy_a;
    logic [1:0]  rd_busy_b;
    logic        ready_a, ready_b;
    logic [31:0] vec_a;
    logic [23:0] vec_b;

    assign rd_addr_a = {pa2, pa1, pa0};
    assign rd_addr_b = {pa1, pa0};

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .NRP(3), .BYPASS(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr_a), .o_rd_data(rd_data_a),
        .o_rd_busy(rd_busy_a), .i_wr_en(we), .i_wr_addr(wa), .i_wr_data(wd),
        .i_rsv_en(re), .i_rsv_addr(ra), .o_rsv_ready(ready_a), .o_busy_vec(vec_a));

    regfile_scoreboard #(.XLEN(32), .NREGS(24), .AW(5), .NRP(2), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr_b), .o_rd_data(rd_data_b),
        .o_rd_busy(rd_busy_b), .i_wr_en(we), .i_wr_addr(wa), .i_wr_data(wd),
        .i_rsv_en(re), .i_rsv_addr(ra), .o_rsv_ready(ready_b), .o_busy_vec(vec_b));

    typedef struct {
        string             tag;
        logic [2:0][31:0]  da;
        logic [2:0]        ba;
        logic              ra;
        logic [31:0]       va;
        logic [1:0][31:0]  db;
        logic [1:0]        bb;
        logic              rb;
        logic [23:0]       vb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, one copy per instance (0 = A, 1 = B).
    logic [31:0] mem [2][32];
    bit          bsy [2][32];

    function automatic int nr(input int d);
        return (d == 0) ? 32 : 24;
    endfunction

    function automatic void mclear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                mem[d][r] = '0;
                bsy[d][r] = 1'b0;
            end
    endfunction

    function automatic void mread(input int d, input logic [4:0] a,
                                  output logic [31:0] dv, output logic bv);
        dv = '0;
        bv = 1'b0;
        if (a == 0 || int'(a) >= nr(d)) return;
        if (d == 0 && we && wa == a) dv = wd;
        else begin
            dv = mem[d][a];
            bv = bsy[d][a];
        end
    endfunction

    function automatic logic mready(input int d);
        if (ra == 0 || int'(ra) >= nr(d)) return 1'b1;
        if (we && wa == ra) return 1'b1;
        return !bsy[d][ra];
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, queue the expected outputs, then advance the model past the edge.
    task automatic drive(input int p0, input int p1, input int p2, input int w,
                         input int wadr, input logic [31:0] wdat, input int r,
                         input int radr, input string tag);
        exp_t e;
        logic [31:0] dv;
        logic        bv;
        @(posedge clk);
        #1;
        pa0 = 5'(p0); pa1 = 5'(p1); pa2 = 5'(p2);
        we = (w != 0); wa = 5'(wadr); wd = wdat;
        re = (r != 0); ra = 5'(radr);
        e.tag = tag;
        mread(0, pa0, dv, bv); e.da[0] = dv; e.ba[0] = bv;
        mread(0, pa1, dv, bv); e.da[1] = dv; e.ba[1] = bv;
        mread(0, pa2, dv, bv); e.da[2] = dv; e.ba[2] = bv;
        mread(1, pa0, dv, bv); e.db[0] = dv; e.bb[0] = bv;
        mread(1, pa1, dv, bv); e.db[1] = dv; e.bb[1] = bv;
        e.ra = mready(0);
        e.rb = mready(1);
        for (int i = 0; i < 32; i++) e.va[i] = bsy[0][i];
        for (int i = 0; i < 24; i++) e.vb[i] = bsy[1][i];
        q.push_back(e);
        for (int d = 0; d < 2; d++) begin
            bit acc;
            acc = re && ((d == 0) ? e.ra : e.rb);
            if (we && wa != 0 && int'(wa) < nr(d)) begin
                mem[d][wa] = wd;
                bsy[d][wa] = 1'b0;
            end
            if (acc && ra != 0 && int'(ra) < nr(d)) bsy[d][ra] = 1'b1;
        end
    endtask

    // Reset asserted between edges, with a live writeback on the bus.
    // Everything must read zero before any clock edge arrives.
    task automatic pulse_reset(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pa0 = 5'd5; pa1 = 5'd6; pa2 = 5'd5;
        we = 1'b1; wa = 5'd5; wd = 32'h77; re = 1'b0; ra = 5'd0;
        mclear();
        e.tag = tag;
        e.da = '0; e.ba = '0; e.ra = 1'b1; e.va = '0;
        e.db = '0; e.bb = '0; e.rb = 1'b1; e.vb = '0;
        q.push_back(e);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        we = 1'b0;
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s A.data%0d", me.tag, k), rd_data_a[k*32 +: 32], me.da[k]);
                chk($sformatf("%s A.busy%0d", me.tag, k), 32'(rd_busy_a[k]), 32'(me.ba[k]));
            end
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("%s B.data%0d", me.tag, k), rd_data_b[k*32 +: 32], me.db[k]);
                chk($sformatf("%s B.busy%0d", me.tag, k), 32'(rd_busy_b[k]), 32'(me.bb[k]));
            end
            chk($sformatf("%s A.ready", me.tag), 32'(ready_a), 32'(me.ra));
            chk($sformatf("%s B.ready", me.tag), 32'(ready_b), 32'(me.rb));
            chk($sformatf("%s A.busy_vec", me.tag), vec_a, me.va);
            chk($sformatf("%s B.busy_vec", me.tag), 32'(vec_b), 32'(me.vb));
        end
    end

    initial begin
        mclear();
        pulse_reset("init_reset");

        drive(0, 0, 0, 1, 0, 32'h1234, 0, 0, "wr_x0");
        drive(0, 0, 0, 1, 31, 32'hA5A5A5A5, 0, 0, "wr_x31");
        drive(0, 31, 0, 0, 0, 0, 0, 0, "rd_x0_x31");
        drive(0, 0, 0, 1, 7, 32'h11, 0, 0, "wr_x7");
        drive(7, 7, 7, 1, 7, 32'h22, 0, 0, "bypass_x7");
        drive(7, 7, 7, 0, 0, 0, 0, 0, "post_bypass_x7");
        drive(3, 3, 0, 0, 0, 0, 1, 3, "rsv_x3");
        drive(3, 3, 0, 0, 0, 0, 0, 0, "x3_busy");
        drive(3, 3, 0, 1, 3, 32'h99, 0, 0, "wr_x3");
        drive(3, 3, 0, 0, 0, 0, 0, 0, "x3_clear");
        drive(4, 0, 0, 0, 0, 0, 1, 4, "rsv_x4");
        drive(4, 0, 0, 0, 0, 0, 1, 4, "waw_stall_x4");
        drive(4, 0, 0, 1, 4, 32'h44, 1, 4, "waw_wr_rsv_x4");
        drive(4, 0, 0, 0, 0, 0, 0, 0, "x4_rebusy");
        drive(4, 0, 0, 1, 4, 32'h45, 0, 0, "wr_x4_clear");
        drive(0, 0, 0, 0, 0, 0, 1, 0, "rsv_x0");
        drive(0, 0, 0, 0, 0, 0, 0, 0, "after_rsv_x0");
        drive(0, 0, 0, 1, 9, 32'h5, 0, 0, "wr_x9");
        drive(9, 9, 9, 0, 0, 0, 0, 0, "multiport_x9");
        drive(26, 27, 0, 1, 26, 32'hCAFE, 1, 27, "oor_wr_rsv");
        drive(26, 27, 27, 0, 0, 0, 1, 27, "oor_rd");
        drive(27, 0, 0, 1, 27, 32'h1, 0, 0, "clr_x27");
        drive(5, 6, 0, 1, 5, 32'hDEADBEEF, 1, 6, "wr_x5_rsv_x6");
        drive(5, 6, 0, 0, 0, 0, 0, 0, "pre_reset");
        pulse_reset("mid_reset");
        drive(5, 6, 0, 0, 0, 0, 0, 0, "post_reset");

        for (int i = 0; i < 600; i++) begin
            int p0, wadr;
            wadr = int'($urandom_range(0, 31));
            p0 = ($urandom_range(0, 3) == 0) ? wadr : int'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) pulse_reset("rnd_reset");
            else drive(p0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 1)), wadr, $urandom(),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), "rnd");
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
